// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared debounce state encoding and SR command encodings
package sr_cmd_pkg;
   typedef enum logic [1:0] {DB_LOW, DB_CHK_HIGH, DB_HIGH, DB_CHK_LOW} db_state_t;
   localparam logic [1:0] SR_HOLD    = 2'b00;
   localparam logic [1:0] SR_RST     = 2'b01;
   localparam logic [1:0] SR_SET     = 2'b10;
   localparam logic [1:0] SR_ILLEGAL = 2'b11;
   // Simultaneous presses resolve to HOLD so SR_ILLEGAL can never be produced
   function automatic logic [1:0] sr_cmd(input logic set_rise, input logic reset_rise);
      return (set_rise && !reset_rise) ? SR_SET :
             (reset_rise && !set_rise) ? SR_RST : SR_HOLD;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise and debounce one raw button, flag accepted presses
module btn_debounce
   import sr_cmd_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic lvl,
   output logic rise
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   db_state_t              r_state;
   logic                   r_lvl;
   logic                   r_rise;
   logic                   w_in;
   assign w_in = r_sync[SYNC_STAGES-1];
   assign lvl  = r_lvl;
   assign rise = r_rise;
   // Metastability chain bringing the raw button into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
   end
   // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES equal samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= DB_LOW;
         r_cnt   <= '0;
         r_lvl   <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         case (r_state)
            DB_LOW: begin
               if (w_in) begin
                  r_state <= DB_CHK_HIGH;
                  r_cnt   <= CNT_W'(1);
               end
            end
            DB_CHK_HIGH: begin
               if (!w_in) begin
                  r_state <= DB_LOW;
                  r_cnt   <= '0;
               end else if (r_cnt == LAST) begin
                  r_state <= DB_HIGH;
                  r_cnt   <= '0;
                  r_lvl   <= 1'b1;
                  r_rise  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DB_HIGH: begin
               if (!w_in) begin
                  r_state <= DB_CHK_LOW;
                  r_cnt   <= CNT_W'(1);
               end
            end
            DB_CHK_LOW: begin
               if (w_in) begin
                  r_state <= DB_HIGH;
                  r_cnt   <= '0;
               end else if (r_cnt == LAST) begin
                  r_state <= DB_LOW;
                  r_cnt   <= '0;
                  r_lvl   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= DB_LOW;
               r_cnt   <= '0;
               r_lvl   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turn two debounced buttons into mutually exclusive s/r command pulses
module sr_cmd_gen
   import sr_cmd_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_btn,
   input  logic reset_btn,
   output logic s,
   output logic r,
   output logic conflict,
   output logic set_lvl,
   output logic reset_lvl
);
   logic w_set_rise;
   logic w_reset_rise;
   logic r_s;
   logic r_r;
   logic r_conflict;
   btn_debounce #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
   ) u_set_db (
      .clk(clk), .rst_n(rst_n), .btn(set_btn), .lvl(set_lvl), .rise(w_set_rise)
   );
   btn_debounce #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
   ) u_reset_db (
      .clk(clk), .rst_n(rst_n), .btn(reset_btn), .lvl(reset_lvl), .rise(w_reset_rise)
   );
   assign s        = r_s;
   assign r        = r_r;
   assign conflict = r_conflict;
   // Arbitrate accepted presses into one registered command; collisions drop both
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {r_s, r_r} <= SR_HOLD;
         r_conflict <= 1'b0;
      end else begin
         {r_s, r_r} <= sr_cmd(w_set_rise, w_reset_rise);
         r_conflict <= w_set_rise & w_reset_rise;
      end
   end
endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: randomized and directed checks of sr_cmd_gen against a run-length model
module tb_sr_cmd_gen;
   localparam int SYNC = 2;
   localparam int DC   = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic set_btn = 1'b0;
   logic reset_btn = 1'b0;
   logic s, r, conflict, set_lvl, reset_lvl;
   int errors = 0;
   int checks = 0;
   bit hs[$];
   bit hr[$];
   bit m_lvl_s, m_lvl_r, rise_s, rise_r, e_s, e_r, e_c;
   int run_s, run_r;

   sr_cmd_gen #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .reset_btn(reset_btn),
      .s(s), .r(r), .conflict(conflict), .set_lvl(set_lvl), .reset_lvl(reset_lvl)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Model: accepted level flips once DC consecutive synchronised samples disagree with it
   function automatic void db_step(input bit seen, inout bit lvl, inout int run, output bit rise);
      rise = 1'b0;
      if (seen != lvl) begin
         run++;
         if (run == DC) begin
            lvl  = !lvl;
            run  = 0;
            rise = lvl;
         end
      end else run = 0;
   endfunction

   function automatic void model_clear();
      hs.delete(); hr.delete();
      m_lvl_s = 0; m_lvl_r = 0; rise_s = 0; rise_r = 0;
      e_s = 0; e_r = 0; e_c = 0; run_s = 0; run_r = 0;
   endfunction

   function automatic void model_step();
      bit seen_s, seen_r;
      if (!rst_n) begin
         model_clear();
         return;
      end
      e_s = rise_s && !rise_r;
      e_r = rise_r && !rise_s;
      e_c = rise_s && rise_r;
      hs.push_back(set_btn);
      hr.push_back(reset_btn);
      seen_s = (hs.size() > SYNC) ? hs[hs.size()-1-SYNC] : 1'b0;
      seen_r = (hr.size() > SYNC) ? hr[hr.size()-1-SYNC] : 1'b0;
      if (hs.size() > SYNC + 1) begin
         void'(hs.pop_front());
         void'(hr.pop_front());
      end
      db_step(seen_s, m_lvl_s, run_s, rise_s);
      db_step(seen_r, m_lvl_r, run_r, rise_r);
   endfunction

   task automatic cyc(input bit sb, input bit rb);
      set_btn   = sb;
      reset_btn = rb;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         cyc(1'($urandom_range(1)), 1'($urandom_range(1)));
         checks++;
         if ({s, r, conflict, set_lvl, reset_lvl} !== 5'b0) begin
            errors++;
            $display("FAIL reset cyc %0d: got %b want 00000", i, {s, r, conflict, set_lvl, reset_lvl});
         end
      end
      set_btn = 1'b0; reset_btn = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) cyc(0, 0);
   endtask

   task automatic test_clean();
      int pulses = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1, 0);
         pulses += int'(s);
         checks++;
         if (s !== (i == 6) || r !== 1'b0 || {s, r, conflict, set_lvl, reset_lvl} !== {e_s, e_r, e_c, m_lvl_s, m_lvl_r}) begin
            errors++;
            $display("FAIL clean edge %0d: got %b want %b", i, {s, r, conflict, set_lvl, reset_lvl}, {e_s, e_r, e_c, m_lvl_s, m_lvl_r});
         end
      end
      checks++;
      if (set_lvl !== 1'b1 || pulses != 1) begin
         errors++;
         $display("FAIL clean held: set_lvl=%b pulses=%0d want 1 and 1", set_lvl, pulses);
      end
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0);
         checks++;
         if ({s, r, conflict, set_lvl, reset_lvl} !== {e_s, e_r, e_c, m_lvl_s, m_lvl_r} || set_lvl !== (i < 5)) begin
            errors++;
            $display("FAIL clean release %0d: got %b want %b", i, {s, r, conflict, set_lvl, reset_lvl}, {e_s, e_r, e_c, m_lvl_s, m_lvl_r});
         end
      end
   endtask

   task automatic test_bounce();
      bit pat[8] = '{1, 1, 0, 1, 1, 1, 1, 1};
      for (int i = 0; i < 16; i++) begin
         cyc(i < 8 ? pat[i] : 1'b1, 0);
         checks++;
         if (s !== (i == 9) || {s, r, conflict, set_lvl, reset_lvl} !== {e_s, e_r, e_c, m_lvl_s, m_lvl_r}) begin
            errors++;
            $display("FAIL bounce edge %0d: got %b want s=%0d model %b", i, {s, r, conflict, set_lvl, reset_lvl}, (i == 9), {e_s, e_r, e_c, m_lvl_s, m_lvl_r});
         end
      end
      for (int i = 0; i < 10; i++) cyc(0, 0);
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 12; i++) begin
         cyc(0, i < 3);
         checks++;
         if (r !== 1'b0 || reset_lvl !== 1'b0 || {s, r, conflict, set_lvl, reset_lvl} !== {e_s, e_r, e_c, m_lvl_s, m_lvl_r}) begin
            errors++;
            $display("FAIL glitch edge %0d: got r=%b reset_lvl=%b want 0 0", i, r, reset_lvl);
         end
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 12; i++) begin
         cyc(1, 1);
         checks++;
         if (conflict !== (i == 6) || s !== 1'b0 || r !== 1'b0) begin
            errors++;
            $display("FAIL simul edge %0d: got s=%b r=%b conflict=%b want 0 0 %0d", i, s, r, conflict, (i == 6));
         end
      end
      for (int i = 0; i < 10; i++) cyc(0, 0);
      for (int i = 0; i < 12; i++) begin
         cyc(0, 1);
         checks++;
         if (r !== (i == 6) || s !== 1'b0 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL simul_then_reset edge %0d: got s=%b r=%b conflict=%b want 0 %0d 0", i, s, r, conflict, (i == 6));
         end
      end
      for (int i = 0; i < 10; i++) cyc(0, 0);
   endtask

   task automatic test_held_repeat();
      int pulses = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(1, 0);
         pulses += int'(s);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL held pulses: got %0d want 1", pulses);
      end
      for (int i = 0; i < 10; i++) cyc(0, 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1, 0);
         pulses += int'(s);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL repeat pulses: got %0d want 1", pulses);
      end
      for (int i = 0; i < 10; i++) cyc(0, 0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) cyc(1, 0);
      @(posedge clk);
      model_step();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({s, r, conflict, set_lvl, reset_lvl} !== 5'b0) begin
         errors++;
         $display("FAIL reset_mid async: got %b want 00000", {s, r, conflict, set_lvl, reset_lvl});
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) cyc(1, 0);
      rst_n = 1'b1;
      model_clear();
      for (int i = 0; i < 12; i++) begin
         cyc(1, 0);
         checks++;
         if (s !== (i == 6) || {s, r, conflict, set_lvl, reset_lvl} !== {e_s, e_r, e_c, m_lvl_s, m_lvl_r}) begin
            errors++;
            $display("FAIL reset_mid edge %0d: got %b want s=%0d model %b", i, {s, r, conflict, set_lvl, reset_lvl}, (i == 6), {e_s, e_r, e_c, m_lvl_s, m_lvl_r});
         end
      end
      for (int i = 0; i < 10; i++) cyc(0, 0);
   endtask

   task automatic test_random();
      bit sb = 0, rb = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(5) == 0) sb = !sb;
         if ($urandom_range(5) == 0) rb = !rb;
         cyc(sb, rb);
         checks++;
         if ((s & r) !== 1'b0 || {s, r, conflict, set_lvl, reset_lvl} !== {e_s, e_r, e_c, m_lvl_s, m_lvl_r}) begin
            errors++;
            $display("FAIL random cyc %0d: got %b want %b", i, {s, r, conflict, set_lvl, reset_lvl}, {e_s, e_r, e_c, m_lvl_s, m_lvl_r});
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_clean();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_held_repeat();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
